main_mem_arbiter: RTL and testbench

Shares the single main-memory port and the 16-entry lock (semaphore) table between NCORE pipelined cores. Each core's decode stage raises read/write requests and lock/unlock requests and stalls until it receives a one-cycle `main_mem_ac` / `lock_ac` pulse. The block sits between the core array and the main-memory macro. It owns the round-robin memory scheduler and the lock ownership table.

---
 rtl/memarb_pkg.sv | 46 ++++
 rtl/main_mem_arbiter_locktable.sv | 69 ++++++
 rtl/main_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_main_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// Shared types and helpers for the main-memory arbiter and its lock table.
package memarb_pkg;

  localparam int MAX_NCORE = 8;
  localparam int CID_W     = $clog2(MAX_NCORE);
  localparam int LOCK_N    = 16;
  localparam int LOCK_W    = 4;
  localparam int DATA_W    = 16;

  // state     | meaning
  // ST_IDLE   | scanning requests round-robin from the pointer
  // ST_ACCESS | strobe held to the memory macro, latency counting down
  // ST_DONE   | one-cycle ack to the served core, pointer advances
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } mem_state_t;

  typedef struct packed {
    logic             valid;
    logic [CID_W-1:0] owner;
  } lock_entry_t;

  // Returns {hit, index} of the first set request at or after ptr, wrapping at n.
  function automatic logic [CID_W:0] rr_pick(input logic [MAX_NCORE-1:0] req,
                                             input logic [CID_W-1:0]     ptr,
                                             input int                   n);
    logic [CID_W:0]   res;
    logic [CID_W-1:0] idx;
    res = '0;
    // Walk from the farthest offset down so the nearest hit is the one kept.
    for (int k = MAX_NCORE - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = CID_W'((int'(ptr) + k) % n);
        if (req[idx]) res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  function automatic logic [CID_W-1:0] next_id(input logic [CID_W-1:0] id, input int n);
    return (int'(id) >= n - 1) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/main_mem_arbiter_locktable.sv
// Lock (semaphore) table with its own round-robin selector; one operation per cycle.
module locktable
  import memarb_pkg::*;
#(
  parameter int NCORE = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NCORE-1:0]          lock_en,
  input  logic [NCORE-1:0]          unlock_en,
  input  logic [NCORE*LOCK_W-1:0]   lock_adr,
  output logic [NCORE-1:0]          lock_ac,
  output logic [LOCK_N-1:0]         lock_owner_valid
);

  lock_entry_t              r_tbl [LOCK_N];
  logic [CID_W-1:0]         r_ptr;
  logic [NCORE-1:0]         r_ac;

  logic [NCORE-1:0]         w_req;
  logic [CID_W:0]           w_pick;
  logic [CID_W-1:0]         w_lid;
  logic [MAX_NCORE-1:0]     w_unl_ext;
  logic [LOCK_W*MAX_NCORE-1:0] w_ladr_ext;
  logic [LOCK_W-1:0]        w_ladr;
  lock_entry_t              w_ent;

  // A core whose ack is pulsing this cycle is masked so a held level is not served twice.
  assign w_req      = (lock_en | unlock_en) & ~r_ac;
  assign w_pick     = rr_pick(MAX_NCORE'(w_req), r_ptr, NCORE);
  assign w_lid      = w_pick[CID_W-1:0];
  assign w_unl_ext  = MAX_NCORE'(unlock_en);
  assign w_ladr_ext = (LOCK_W*MAX_NCORE)'(lock_adr);
  assign w_ladr     = w_ladr_ext[{w_lid, 2'b00} +: LOCK_W];
  assign w_ent      = r_tbl[w_ladr];

  // Serve one lock/unlock per cycle; a blocked lock still advances the pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LOCK_N; i++) r_tbl[i] <= '0;
      r_ptr <= '0;
      r_ac  <= '0;
    end else begin
      r_ac <= '0;
      if (w_pick[CID_W]) begin
        r_ptr <= next_id(w_lid, NCORE);
        if (w_unl_ext[w_lid]) begin
          r_ac <= NCORE'(1) << w_lid;
          if (w_ent.valid && (w_ent.owner == w_lid)) r_tbl[w_ladr] <= '0;
        end else if (!w_ent.valid) begin
          r_ac                <= NCORE'(1) << w_lid;
          r_tbl[w_ladr].valid <= 1'b1;
          r_tbl[w_ladr].owner <= w_lid;
        end else if (w_ent.owner == w_lid) begin
          r_ac <= NCORE'(1) << w_lid;
        end
      end
    end
  end

  // Flatten entry valid flags for observation.
  always_comb begin
    lock_owner_valid = '0;
    for (int i = 0; i < LOCK_N; i++) lock_owner_valid[i] = r_tbl[i].valid;
  end

  assign lock_ac = r_ac;

endmodule

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter for the shared main-memory port plus the shared lock table.
module main_mem_arbiter
  import memarb_pkg::*;
#(
  parameter int NCORE   = 2,
  parameter int MEM_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCORE-1:0]       main_mem_read,
  input  logic [NCORE-1:0]       main_mem_write,
  input  logic [NCORE*16-1:0]    req_adr,
  input  logic [NCORE*16-1:0]    req_wdat,
  input  logic [NCORE-1:0]       lock_en,
  input  logic [NCORE-1:0]       unlock_en,
  input  logic [NCORE*4-1:0]     lock_adr,
  output logic [NCORE-1:0]       main_mem_ac,
  output logic [NCORE-1:0]       lock_ac,
  output logic [15:0]            rdat,
  output logic [15:0]            mem_adr,
  output logic [15:0]            mem_wdat,
  output logic                   mem_re,
  output logic                   mem_we,
  input  logic [15:0]            mem_rdat,
  output logic [15:0]            lock_owner_valid
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  mem_state_t                  r_state;
  logic [3:0]                  r_cnt;
  logic [CID_W-1:0]            r_id;
  logic [CID_W-1:0]            r_rr_ptr;
  logic                        r_op_we;
  logic [DATA_W-1:0]           r_adr;
  logic [DATA_W-1:0]           r_wdat;
  logic [DATA_W-1:0]           r_rdat;
  logic                        r_mem_re;
  logic                        r_mem_we;
  logic [NCORE-1:0]            r_ac;

  logic [NCORE-1:0]            w_req;
  logic [CID_W:0]              w_pick;
  logic [CID_W-1:0]            w_pid;
  logic [MAX_NCORE-1:0]        w_wr_ext;
  logic [DATA_W*MAX_NCORE-1:0] w_adr_ext;
  logic [DATA_W*MAX_NCORE-1:0] w_wdat_ext;

  assign w_req      = main_mem_read | main_mem_write;
  assign w_pick     = rr_pick(MAX_NCORE'(w_req), r_rr_ptr, NCORE);
  assign w_pid      = w_pick[CID_W-1:0];
  assign w_wr_ext   = MAX_NCORE'(main_mem_write);
  assign w_adr_ext  = (DATA_W*MAX_NCORE)'(req_adr);
  assign w_wdat_ext = (DATA_W*MAX_NCORE)'(req_wdat);

  // Memory FSM: latch winner in IDLE, hold strobe for MEM_LAT cycles, ack in DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_id     <= '0;
      r_rr_ptr <= '0;
      r_op_we  <= 1'b0;
      r_adr    <= '0;
      r_wdat   <= '0;
      r_rdat   <= '0;
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;
      r_ac     <= '0;
    end else begin
      r_ac <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick[CID_W]) begin
            // Read and write together resolve to a write.
            r_id     <= w_pid;
            r_adr    <= w_adr_ext[{w_pid, 4'b0000} +: DATA_W];
            r_wdat   <= w_wdat_ext[{w_pid, 4'b0000} +: DATA_W];
            r_op_we  <= w_wr_ext[w_pid];
            r_mem_we <= w_wr_ext[w_pid];
            r_mem_re <= ~w_wr_ext[w_pid];
            r_cnt    <= CNT_INIT;
            r_state  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            r_ac     <= NCORE'(1) << r_id;
            if (!r_op_we) r_rdat <= mem_rdat;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          r_rr_ptr <= next_id(r_id, NCORE);
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign main_mem_ac = r_ac;
  assign rdat        = r_rdat;
  assign mem_adr     = r_adr;
  assign mem_wdat    = r_wdat;
  assign mem_re      = r_mem_re;
  assign mem_we      = r_mem_we;

  locktable #(.NCORE(NCORE)) u_locktable (
    .clk              (clk),
    .reset            (reset),
    .lock_en          (lock_en),
    .unlock_en        (unlock_en),
    .lock_adr         (lock_adr),
    .lock_ac          (lock_ac),
    .lock_owner_valid (lock_owner_valid)
  );

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter: memory scoreboard plus lock-table sequence.
module tb_main_mem_arbiter;

  localparam int NCORE   = 2;
  localparam int MEM_LAT = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NCORE-1:0]   main_mem_read = '0;
  logic [NCORE-1:0]   main_mem_write = '0;
  logic [NCORE*16-1:0] req_adr = '0;
  logic [NCORE*16-1:0] req_wdat = '0;
  logic [NCORE-1:0]   lock_en = '0;
  logic [NCORE-1:0]   unlock_en = '0;
  logic [NCORE*4-1:0] lock_adr = '0;
  logic [NCORE-1:0]   main_mem_ac;
  logic [NCORE-1:0]   lock_ac;
  logic [15:0]        rdat, mem_adr, mem_wdat, mem_rdat;
  logic               mem_re, mem_we;
  logic [15:0]        lock_owner_valid;

  main_mem_arbiter #(.NCORE(NCORE), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .main_mem_read(main_mem_read), .main_mem_write(main_mem_write),
    .req_adr(req_adr), .req_wdat(req_wdat),
    .lock_en(lock_en), .unlock_en(unlock_en), .lock_adr(lock_adr),
    .main_mem_ac(main_mem_ac), .lock_ac(lock_ac), .rdat(rdat),
    .mem_adr(mem_adr), .mem_wdat(mem_wdat), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdat(mem_rdat), .lock_owner_valid(lock_owner_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          core;
    logic [15:0] adr;
    logic [15:0] wdat;
    logic        we;
    logic [15:0] rdat;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  logic [15:0] last_rdat = 16'h0000;
  bit          saw_re = 0;
  bit          saw_we = 0;
  int          re_cycles = 0;
  bit          spacing_on = 0;
  int          last_ack = -1;

  function automatic logic [15:0] rd_model(input logic [15:0] a);
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  assign mem_rdat = mem_re ? rd_model(mem_adr) : 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory-side monitor: strobes against the queue head, acks pop the queue.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_re) begin saw_re = 1; re_cycles++; end
      if (mem_we) saw_we = 1;
      if (mem_re || mem_we) begin
        if (q.size() == 0) check("strobe_unexpected", {mem_re, mem_we}, 0);
        else begin
          check("mem_adr", mem_adr, q[0].adr);
          check("mem_we", mem_we, q[0].we);
          check("mem_re", mem_re, !q[0].we);
          if (q[0].we) check("mem_wdat", mem_wdat, q[0].wdat);
        end
      end
      if (main_mem_ac != 0) begin
        if (q.size() == 0) check("ack_unexpected", main_mem_ac, 0);
        else begin
          mon_e = q.pop_front();
          check("ack_core", main_mem_ac, 1 << mon_e.core);
          if (!mon_e.we) last_rdat = mon_e.rdat;
          check("rdat", rdat, last_rdat);
          if (spacing_on) begin
            if (last_ack >= 0) check("ack_spacing", cyc - last_ack, MEM_LAT + 2);
            last_ack = cyc;
          end
        end
      end
    end
  end

  task automatic mem_req(input int c, input bit rd, input bit wr,
                         input logic [15:0] a, input logic [15:0] d);
    main_mem_read[c]       = rd;
    main_mem_write[c]      = wr;
    req_adr[16*c +: 16]    = a;
    req_wdat[16*c +: 16]   = d;
  endtask

  task automatic push(input int c, input bit wr, input logic [15:0] a, input logic [15:0] d);
    q.push_back('{core: c, adr: a, wdat: d, we: wr, rdat: rd_model(a)});
  endtask

  // Waits for n memory acks; drops each acked core (or everything at the end when hold=1).
  task automatic wait_mem_acks(input int n, input int budget, input bit hold,
                               output int got, output int first_k);
    got = 0;
    first_k = -1;
    for (int k = 1; k <= budget && got < n; k++) begin
      @(negedge clk);
      if (main_mem_ac != 0) begin
        got++;
        if (first_k < 0) first_k = k;
        if (hold && got == n) begin
          main_mem_read  = '0;
          main_mem_write = '0;
        end else if (!hold) begin
          main_mem_read  = main_mem_read  & ~main_mem_ac;
          main_mem_write = main_mem_write & ~main_mem_ac;
        end
      end
    end
  endtask

  task automatic lock_req(input int c, input bit lk, input bit ul, input logic [3:0] a);
    lock_en[c]          = lk;
    unlock_en[c]        = ul;
    lock_adr[4*c +: 4]  = a;
  endtask

  task automatic wait_lock(input int c, input int budget, output int kk);
    kk = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (lock_ac[c]) begin
        kk = k;
        lock_en[c]   = 1'b0;
        unlock_en[c] = 1'b0;
        break;
      end
    end
  endtask

  int got, fk, kk, nack;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_ac", main_mem_ac, 0);
    check("rst_lock_ac", lock_ac, 0);
    check("rst_rdat", rdat, 0);
    check("rst_mem_adr", mem_adr, 0);
    check("rst_mem_wdat", mem_wdat, 0);
    check("rst_lock_valid", lock_owner_valid, 0);
    reset = 1'b1;

    // Single read by core 0: latency and strobe width
    re_cycles = 0;
    mem_req(0, 1, 0, 16'h0040, 16'h0000);
    push(0, 0, 16'h0040, 16'h0000);
    wait_mem_acks(1, 12, 0, got, fk);
    check("t1_acks", got, 1);
    check("t1_latency", fk, MEM_LAT + 1);
    check("t1_re_cycles", re_cycles, MEM_LAT);
    check("t1_rdat", rdat, 16'hBEEF);
    @(negedge clk);
    check("t1_ack_pulse", main_mem_ac, 0);

    // Two cores writing continuously: pointer now at core 1
    repeat (2) @(negedge clk);
    mem_req(0, 0, 1, 16'h0100, 16'h1111);
    mem_req(1, 0, 1, 16'h0200, 16'h2222);
    push(1, 1, 16'h0200, 16'h2222);
    push(0, 1, 16'h0100, 16'h1111);
    push(1, 1, 16'h0200, 16'h2222);
    push(0, 1, 16'h0100, 16'h1111);
    last_ack = -1;
    spacing_on = 1;
    wait_mem_acks(4, 30, 1, got, fk);
    spacing_on = 0;
    check("t2_acks", got, 4);
    check("t2_rdat_hold", rdat, 16'hBEEF);
    repeat (3) @(negedge clk);
    check("t2_queue_drained", q.size(), 0);

    // Read and write together resolve to a write
    saw_re = 0;
    saw_we = 0;
    mem_req(0, 1, 1, 16'h0010, 16'h3333);
    push(0, 1, 16'h0010, 16'h3333);
    wait_mem_acks(1, 12, 0, got, fk);
    check("t6_acks", got, 1);
    check("t6_no_re", saw_re, 0);
    check("t6_we_seen", saw_we, 1);

    // Lock: core 1 takes entry 5, core 0 is blocked
    lock_req(1, 1, 0, 4'd5);
    wait_lock(1, 5, kk);
    check("l1_ack", kk != -1, 1);
    check("l1_valid", lock_owner_valid, 16'h0020);
    @(negedge clk);
    check("l1_pulse", lock_ac[1], 0);
    lock_req(0, 1, 0, 4'd5);
    nack = 0;
    repeat (6) begin @(negedge clk); nack += int'(lock_ac[0]); end
    check("l2_blocked", nack, 0);
    lock_req(1, 0, 1, 4'd5);
    wait_lock(1, 6, kk);
    check("l3_unlock_ack", kk != -1, 1);
    wait_lock(0, 3, kk);
    check("l3_handoff", (kk >= 1 && kk <= 2), 1);
    check("l3_valid", lock_owner_valid, 16'h0020);

    // Entry 5 now belongs to core 0: core 1 blocked, core 0 re-lock acked
    lock_req(1, 1, 0, 4'd5);
    nack = 0;
    repeat (5) begin @(negedge clk); nack += int'(lock_ac[1]); end
    lock_req(1, 0, 0, 4'd0);
    check("l4_other_blocked", nack, 0);
    lock_req(0, 1, 0, 4'd5);
    wait_lock(0, 4, kk);
    check("l4_same_owner_ack", kk != -1, 1);
    check("l4_valid", lock_owner_valid, 16'h0020);

    // Unlock by non-owner is acked but leaves the entry alone
    lock_req(1, 1, 0, 4'd7);
    wait_lock(1, 4, kk);
    check("l5_lock7", kk != -1, 1);
    check("l5_valid", lock_owner_valid, 16'h00A0);
    lock_req(0, 0, 1, 4'd7);
    wait_lock(0, 4, kk);
    check("l5_foreign_unlock_ack", kk != -1, 1);
    check("l5_valid_kept", lock_owner_valid, 16'h00A0);
    lock_req(1, 0, 1, 4'd7);
    wait_lock(1, 4, kk);
    check("l5_owner_unlock", kk != -1, 1);
    check("l5_valid_cleared", lock_owner_valid, 16'h0020);

    // Lock and unlock together: unlock wins
    lock_req(0, 1, 1, 4'd5);
    wait_lock(0, 4, kk);
    check("l6_ack", kk != -1, 1);
    check("l6_valid", lock_owner_valid, 16'h0000);

    // Reset during an access; hold a lock first so the table clear is visible
    lock_req(0, 1, 0, 4'd3);
    wait_lock(0, 4, kk);
    check("r_lock3", lock_owner_valid, 16'h0008);
    mem_req(1, 1, 0, 16'h0300, 16'h0000);
    push(1, 0, 16'h0300, 16'h0000);
    kk = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mem_re) begin kk = k; break; end
    end
    check("r_access_seen", kk != -1, 1);
    reset = 1'b0;
    mem_req(1, 0, 0, 16'h0000, 16'h0000);
    @(negedge clk);
    q.delete();
    last_rdat = 16'h0000;
    check("r_mem_re", mem_re, 0);
    check("r_mem_we", mem_we, 0);
    check("r_mem_ac", main_mem_ac, 0);
    check("r_lock_valid", lock_owner_valid, 0);
    check("r_rdat", rdat, 0);
    reset = 1'b1;
    nack = 0;
    repeat (5) begin @(negedge clk); nack += int'(main_mem_ac != 0); end
    check("r_no_ack", nack, 0);

    // Both cores request after reset: core 0 first
    mem_req(0, 1, 0, 16'h0040, 16'h0000);
    mem_req(1, 1, 0, 16'h0300, 16'h0000);
    push(0, 0, 16'h0040, 16'h0000);
    push(1, 0, 16'h0300, 16'h0000);
    wait_mem_acks(2, 20, 0, got, fk);
    check("r_post_acks", got, 2);
    check("r_post_rdat", rdat, 16'h0300 ^ 16'h5A5A);
    repeat (3) @(negedge clk);
    check("end_queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
